// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the Wishbone RAM arbiter:
//   - arb_state_t            : arbiter FSM states (IDLE / OWNED / ABORT)
//   - DEFAULT_NMASTERS       : default number of masters sharing the RAM port
//   - DEFAULT_TIMEOUT_CYCLES : default stalled-strobe limit (timeout build only)
//   - idx_width()            : width of a master index, never below one bit
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int DEFAULT_NMASTERS       = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWNED = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_t;

    // Width needed to hold a master index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// -----------------------------------------------------------------------------
// wb_rr_picker
// Combinational round-robin selector. Searches the request vector starting at
// last_owner_i+1 (mod NMASTERS) and returns the first requesting index.
// Ports:
//   req_i        in  NMASTERS  request vector (one bit per master)
//   last_owner_i in  LW        index of the most recent owner
//   next_owner_o out LW        selected master index (0 when nothing requests)
//   valid_o      out 1         at least one request present
// -----------------------------------------------------------------------------
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NMASTERS = DEFAULT_NMASTERS,
    parameter int LW       = idx_width(NMASTERS)
) (
    input  logic [NMASTERS-1:0] req_i,
    input  logic [LW-1:0]       last_owner_i,
    output logic [LW-1:0]       next_owner_o,
    output logic                valid_o
);

    int          cand_s;
    logic [LW-1:0] cand_idx_s;

    // Walk candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        next_owner_o = {LW{1'b0}};
        valid_o      = |req_i;
        cand_s       = 0;
        cand_idx_s   = {LW{1'b0}};
        for (int i = NMASTERS; i >= 1; i--) begin
            cand_s     = (int'(last_owner_i) + i) % NMASTERS;
            cand_idx_s = cand_s[LW-1:0];
            if (req_i[cand_idx_s]) begin
                next_owner_o = cand_idx_s;
            end else begin
                next_owner_o = next_owner_o;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
// Round-robin arbiter letting NMASTERS Wishbone masters share one RAM slave.
// An owner keeps the bus for as long as its CYC stays high (burst lock); there
// is always at least one idle cycle between two owners. Slave-side signals and
// terminations are routed combinationally from/to the registered owner.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stalled-strobe watchdog.
// After TIMEOUT_CYCLES consecutive stalled cycles the owner gets a one-cycle
// ERR, the slave cycle is dropped and the arbiter waits in ABORT until the
// owner releases CYC.
//
// Ports:
//   p_clk, p_reset           clock, synchronous active-high reset
//   m_wb_*_I  (per master)   ADR, DAT, SEL, CYC, STB, WE from each master
//   m_wb_ACK/ERR/RTY_O       per-master terminations (owner only)
//   m_wb_DAT_O               read data broadcast to all masters
//   p_wb_*_O                 ADR, DAT, SEL, CYC, STB, WE to the RAM slave
//   p_wb_DAT/ACK/ERR/RTY_I   read data and terminations from the RAM slave
//   grant_o                  registered one-hot owner, zero when idle
// -----------------------------------------------------------------------------
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NMASTERS = DEFAULT_NMASTERS
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                     p_clk,
    input  logic                     p_reset,
    input  logic [NMASTERS-1:0][31:0] m_wb_ADR_I,
    input  logic [NMASTERS-1:0][31:0] m_wb_DAT_I,
    input  logic [NMASTERS-1:0][3:0]  m_wb_SEL_I,
    input  logic [NMASTERS-1:0]       m_wb_CYC_I,
    input  logic [NMASTERS-1:0]       m_wb_STB_I,
    input  logic [NMASTERS-1:0]       m_wb_WE_I,
    output logic [NMASTERS-1:0]       m_wb_ACK_O,
    output logic [NMASTERS-1:0]       m_wb_ERR_O,
    output logic [NMASTERS-1:0]       m_wb_RTY_O,
    output logic [31:0]               m_wb_DAT_O,
    output logic [31:0]               p_wb_ADR_O,
    output logic [31:0]               p_wb_DAT_O,
    output logic [3:0]                p_wb_SEL_O,
    output logic                      p_wb_CYC_O,
    output logic                      p_wb_STB_O,
    output logic                      p_wb_WE_O,
    input  logic [31:0]               p_wb_DAT_I,
    input  logic                      p_wb_ACK_I,
    input  logic                      p_wb_ERR_I,
    input  logic                      p_wb_RTY_I,
    output logic [NMASTERS-1:0]       grant_o
);

    localparam int LW = idx_width(NMASTERS);

    arb_state_t          state_q, state_d;
    logic [LW-1:0]       owner_q, owner_d;
    logic [LW-1:0]       last_owner_q, last_owner_d;
    logic [NMASTERS-1:0] grant_q, grant_d;

    logic [LW-1:0]       pick_idx_s;
    logic                pick_valid_s;
    logic [NMASTERS-1:0] pick_onehot_s;
    logic                owned_s;
    logic                owner_cyc_s;
    logic                owner_stb_s;
    logic                timeout_hit_s;

    wb_rr_picker #(
        .NMASTERS (NMASTERS),
        .LW       (LW)
    ) u_picker (
        .req_i        (m_wb_CYC_I),
        .last_owner_i (last_owner_q),
        .next_owner_o (pick_idx_s),
        .valid_o      (pick_valid_s)
    );

    // Decode the picked index into a one-hot grant and sample owner controls.
    always_comb begin
        pick_onehot_s             = {NMASTERS{1'b0}};
        pick_onehot_s[pick_idx_s] = 1'b1;
        owned_s                   = (state_q == ST_OWNED);
        owner_cyc_s               = m_wb_CYC_I[owner_q];
        owner_stb_s               = m_wb_STB_I[owner_q];
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          stall_s;

    // A stalled cycle is an owned strobe with no termination; the hit fires on
    // the TIMEOUT_CYCLES-th consecutive one. Counter restarts after a hit.
    always_comb begin
        stall_s = owned_s & owner_stb_s & ~(p_wb_ACK_I | p_wb_ERR_I | p_wb_RTY_I);
        timeout_hit_s = stall_s && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
        if (stall_s && !timeout_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_d = {CW{1'b0}};
        end
    end

    // Stalled-strobe counter register.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            tmo_cnt_q <= {CW{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Without the watchdog a stalled slave simply holds the bus.
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Slave-side mux: follow the owner while OWNED, otherwise drive zeros.
    always_comb begin
        if (owned_s) begin
            p_wb_ADR_O = m_wb_ADR_I[owner_q];
            p_wb_DAT_O = m_wb_DAT_I[owner_q];
            p_wb_SEL_O = m_wb_SEL_I[owner_q];
            p_wb_CYC_O = owner_cyc_s;
            p_wb_STB_O = owner_stb_s;
            p_wb_WE_O  = m_wb_WE_I[owner_q];
        end else begin
            p_wb_ADR_O = 32'h0000_0000;
            p_wb_DAT_O = 32'h0000_0000;
            p_wb_SEL_O = 4'h0;
            p_wb_CYC_O = 1'b0;
            p_wb_STB_O = 1'b0;
            p_wb_WE_O  = 1'b0;
        end
    end

    // Termination routing: only the owner sees slave terminations. This keys on
    // the registered state, so a termination coinciding with CYC fall still lands.
    always_comb begin
        m_wb_ACK_O = {NMASTERS{1'b0}};
        m_wb_ERR_O = {NMASTERS{1'b0}};
        m_wb_RTY_O = {NMASTERS{1'b0}};
        m_wb_DAT_O = p_wb_DAT_I;
        if (owned_s) begin
            m_wb_ACK_O[owner_q] = p_wb_ACK_I;
            m_wb_ERR_O[owner_q] = p_wb_ERR_I | timeout_hit_s;
            m_wb_RTY_O[owner_q] = p_wb_RTY_I;
        end else begin
            m_wb_ACK_O = {NMASTERS{1'b0}};
        end
    end

    // Arbiter next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_OWNED;
                    owner_d = pick_idx_s;
                    grant_d = pick_onehot_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!owner_cyc_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = {NMASTERS{1'b0}};
                end else if (timeout_hit_s) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_OWNED;
                end
            end
            ST_ABORT: begin
                if (!owner_cyc_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = {NMASTERS{1'b0}};
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NMASTERS{1'b0}};
            end
        endcase
    end

    // Arbiter state registers; reset makes master 0 the first candidate.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= {LW{1'b0}};
            last_owner_q <= LW'(NMASTERS - 1);
            grant_q      <= {NMASTERS{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_ram_arbiter
// Self-checking bench for wb_ram_arbiter with two masters. Inputs change just
// after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_ram_arbiter;

    localparam int NM = 2;

    logic                 p_clk;
    logic                 p_reset;
    logic [NM-1:0][31:0]  m_wb_ADR_I;
    logic [NM-1:0][31:0]  m_wb_DAT_I;
    logic [NM-1:0][3:0]   m_wb_SEL_I;
    logic [NM-1:0]        m_wb_CYC_I;
    logic [NM-1:0]        m_wb_STB_I;
    logic [NM-1:0]        m_wb_WE_I;
    logic [NM-1:0]        m_wb_ACK_O;
    logic [NM-1:0]        m_wb_ERR_O;
    logic [NM-1:0]        m_wb_RTY_O;
    logic [31:0]          m_wb_DAT_O;
    logic [31:0]          p_wb_ADR_O;
    logic [31:0]          p_wb_DAT_O;
    logic [3:0]           p_wb_SEL_O;
    logic                 p_wb_CYC_O;
    logic                 p_wb_STB_O;
    logic                 p_wb_WE_O;
    logic [31:0]          p_wb_DAT_I;
    logic                 p_wb_ACK_I;
    logic                 p_wb_ERR_I;
    logic                 p_wb_RTY_I;
    logic [NM-1:0]        grant_o;

    int checks;
    int errors;

    wb_ram_arbiter #(
        .NMASTERS (NM)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .p_clk      (p_clk),
        .p_reset    (p_reset),
        .m_wb_ADR_I (m_wb_ADR_I),
        .m_wb_DAT_I (m_wb_DAT_I),
        .m_wb_SEL_I (m_wb_SEL_I),
        .m_wb_CYC_I (m_wb_CYC_I),
        .m_wb_STB_I (m_wb_STB_I),
        .m_wb_WE_I  (m_wb_WE_I),
        .m_wb_ACK_O (m_wb_ACK_O),
        .m_wb_ERR_O (m_wb_ERR_O),
        .m_wb_RTY_O (m_wb_RTY_O),
        .m_wb_DAT_O (m_wb_DAT_O),
        .p_wb_ADR_O (p_wb_ADR_O),
        .p_wb_DAT_O (p_wb_DAT_O),
        .p_wb_SEL_O (p_wb_SEL_O),
        .p_wb_CYC_O (p_wb_CYC_O),
        .p_wb_STB_O (p_wb_STB_O),
        .p_wb_WE_O  (p_wb_WE_O),
        .p_wb_DAT_I (p_wb_DAT_I),
        .p_wb_ACK_I (p_wb_ACK_I),
        .p_wb_ERR_I (p_wb_ERR_I),
        .p_wb_RTY_I (p_wb_RTY_I),
        .grant_o    (grant_o)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    typedef struct {
        logic          rst;
        logic [1:0]    cyc;     // STB mirrors CYC
        logic          ack;
        logic          err;
        logic [1:0]    e_grant;
        logic          e_cyc;   // expected slave CYC and STB
        logic [31:0]   e_adr;
        logic [1:0]    e_ack;
        logic [1:0]    e_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive after the rising edge, return at the falling edge.
    task automatic step(input logic rst, input logic [1:0] cyc, input logic ack, input logic err);
        @(posedge p_clk);
        #1;
        p_reset    = rst;
        m_wb_CYC_I = cyc;
        m_wb_STB_I = cyc;
        p_wb_ACK_I = ack;
        p_wb_ERR_I = err;
        @(negedge p_clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        m_wb_ADR_I[0] = 32'h4100_0000;
        m_wb_ADR_I[1] = 32'h4200_0010;
        m_wb_DAT_I[0] = 32'hA5A5_0001;
        m_wb_DAT_I[1] = 32'h5A5A_0002;
        m_wb_SEL_I[0] = 4'hF;
        m_wb_SEL_I[1] = 4'h3;
        m_wb_WE_I     = 2'b01;
        m_wb_CYC_I    = 2'b00;
        m_wb_STB_I    = 2'b00;
        p_wb_DAT_I    = 32'hCAFE_F00D;
        p_wb_ACK_I    = 1'b0;
        p_wb_ERR_I    = 1'b0;
        p_wb_RTY_I    = 1'b0;
        p_reset       = 1'b1;

        //          rst   cyc    ack   err   grant  cyc   adr            ack    err
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 32'h4100_0000, 2'b01, 2'b00};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 32'h4100_0000, 2'b00, 2'b00};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 32'h4100_0000, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 32'h4100_0000, 2'b01, 2'b00};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 2'b00};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 32'h4200_0010, 2'b00, 2'b10};

        // Two reset cycles, then check the reset state before any request.
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);

        for (int v = 0; v < 11; v++) begin
            step(vecs[v].rst, vecs[v].cyc, vecs[v].ack, vecs[v].err);
            chk($sformatf("v%0d grant", v),  {30'h0, grant_o},    {30'h0, vecs[v].e_grant});
            chk($sformatf("v%0d p_cyc", v),  {31'h0, p_wb_CYC_O}, {31'h0, vecs[v].e_cyc});
            chk($sformatf("v%0d p_stb", v),  {31'h0, p_wb_STB_O}, {31'h0, vecs[v].e_cyc});
            chk($sformatf("v%0d p_adr", v),  p_wb_ADR_O,          vecs[v].e_adr);
            chk($sformatf("v%0d m_ack", v),  {30'h0, m_wb_ACK_O}, {30'h0, vecs[v].e_ack});
            chk($sformatf("v%0d m_err", v),  {30'h0, m_wb_ERR_O}, {30'h0, vecs[v].e_err});
            if (v == 2) begin
                chk("v2 p_dat", p_wb_DAT_O, 32'hA5A5_0001);
                chk("v2 p_sel", {28'h0, p_wb_SEL_O}, 32'h0000_000F);
                chk("v2 p_we",  {31'h0, p_wb_WE_O},  32'h0000_0001);
                chk("v2 m_dat", m_wb_DAT_O, 32'hCAFE_F00D);
            end
        end

        // Master 1 holds an 8-beat burst while master 0 keeps requesting.
        for (int b = 0; b < 8; b++) begin
            step(1'b0, 2'b11, 1'b1, 1'b0);
            chk($sformatf("burst%0d grant", b), {30'h0, grant_o}, 32'h0000_0002);
            chk($sformatf("burst%0d p_adr", b), p_wb_ADR_O, 32'h4200_0010);
            chk($sformatf("burst%0d m_ack", b), {30'h0, m_wb_ACK_O}, 32'h0000_0002);
        end
        step(1'b0, 2'b01, 1'b0, 1'b0);
        chk("burst_end grant", {30'h0, grant_o}, 32'h0000_0002);
        chk("burst_end p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0000);
        step(1'b0, 2'b01, 1'b0, 1'b0);
        chk("burst_gap grant", {30'h0, grant_o}, 32'h0000_0000);
        step(1'b0, 2'b01, 1'b1, 1'b0);
        chk("m0_after grant", {30'h0, grant_o}, 32'h0000_0001);
        chk("m0_after m_ack", {30'h0, m_wb_ACK_O}, 32'h0000_0001);

        // Hand the bus to master 1, then reset in the middle of its burst.
        step(1'b0, 2'b10, 1'b0, 1'b0);
        chk("handoff grant", {30'h0, grant_o}, 32'h0000_0001);
        step(1'b0, 2'b10, 1'b0, 1'b0);
        chk("handoff gap", {30'h0, grant_o}, 32'h0000_0000);
        step(1'b0, 2'b10, 1'b1, 1'b0);
        chk("m1_burst grant", {30'h0, grant_o}, 32'h0000_0002);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("rst_cycle p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0001);
        chk("rst_cycle m_ack", {30'h0, m_wb_ACK_O}, 32'h0000_0002);
        step(1'b0, 2'b11, 1'b1, 1'b0);
        chk("post_rst p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0000);
        chk("post_rst p_stb", {31'h0, p_wb_STB_O}, 32'h0000_0000);
        chk("post_rst grant", {30'h0, grant_o}, 32'h0000_0000);
        chk("post_rst m_ack", {30'h0, m_wb_ACK_O}, 32'h0000_0000);
        step(1'b0, 2'b11, 1'b0, 1'b0);
        chk("post_rst m0_first", {30'h0, grant_o}, 32'h0000_0001);

`ifdef WB_ARB_TIMEOUT_EN
        // Master 0 stalls against a slave that never terminates.
        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b01, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 2'b01, 1'b0, 1'b0);
            chk($sformatf("tmo%0d p_cyc", k), {31'h0, p_wb_CYC_O}, 32'h0000_0001);
            chk($sformatf("tmo%0d m_err", k), {30'h0, m_wb_ERR_O},
                (k == 16) ? 32'h0000_0001 : 32'h0000_0000);
        end
        step(1'b0, 2'b01, 1'b0, 1'b0);
        chk("abort p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0000);
        chk("abort m_err", {30'h0, m_wb_ERR_O}, 32'h0000_0000);
        chk("abort grant", {30'h0, grant_o}, 32'h0000_0001);
        step(1'b0, 2'b10, 1'b0, 1'b0);
        chk("abort_rel p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0000);
        step(1'b0, 2'b10, 1'b0, 1'b0);
        chk("abort_idle grant", {30'h0, grant_o}, 32'h0000_0000);
        step(1'b0, 2'b10, 1'b0, 1'b0);
        chk("regrant grant", {30'h0, grant_o}, 32'h0000_0002);
        chk("regrant p_cyc", {31'h0, p_wb_CYC_O}, 32'h0000_0001);
`endif

        step(1'b0, 2'b00, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 NMASTERS, 2, number of Wishbone masters sharing the RAM port (2..4).
REQ-003 TIMEOUT_CYCLES, 256, stalled-strobe cycles before forced abort (only with WB_ARB_TIMEOUT_EN).
REQ-004 p_clk  in  1  system clock (100 MHz bus domain).
REQ-005 p_reset  in  1  synchronous active-high reset.
REQ-006 m_wb_ADR_I / m_wb_DAT_I  in  NMASTERS x 32  per-master address / write data.
REQ-007 m_wb_SEL_I  in  NMASTERS x 4  per-master byte select.
REQ-008 m_wb_CYC_I, m_wb_STB_I, m_wb_WE_I  in  NMASTERS  per-master cycle / strobe / write enable.
REQ-009 m_wb_ACK_O, m_wb_ERR_O, m_wb_RTY_O  out  NMASTERS  per-master termination.
REQ-010 m_wb_DAT_O  out  32  read data, broadcast to all masters.
REQ-011 p_wb_ADR_O / p_wb_DAT_O  out  32  address / write data to RAM slave.
REQ-012 p_wb_SEL_O  out  4; p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O  out  1 each: to RAM slave.
REQ-013 p_wb_DAT_I  in  32; p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I  in  1 each: from RAM slave.
REQ-014 grant_o  out  NMASTERS  one-hot registered owner; all-zero when idle.

Function
REQ-015 FSM states SHALL be IDLE, OWNED, ABORT.
REQ-016 IDLE: if any m_wb_CYC_I high, pick owner round-robin starting at last_owner+1 (mod NMASTERS), register grant_o, go to OWNED; else stay.
REQ-017 Grant latency: request seen in cycle N, slave-side signals driven from owner in cycle N+1.
REQ-018 OWNED: p_wb_ADR/DAT/SEL/CYC/STB/WE_O SHALL combinationally follow the owner's inputs; owner keeps the bus across any number of strobes while its CYC_I stays high (burst lock).
REQ-019 Slave ACK/ERR/RTY SHALL route combinationally to owner only; non-owners see 0.
REQ-020 Owner CYC_I low in OWNED: next state IDLE, last_owner <= owner, grant_o <= 0; minimum one idle cycle between owners.
REQ-021 Termination and owner CYC_I fall in the same cycle: termination SHALL still reach the owner that cycle.
REQ-022 With no owner, slave-side outputs SHALL be 0 (ADR, DAT, SEL, CYC, STB, WE).
REQ-023 Requests from non-owners SHALL be held pending, never dropped; fairness: no master waits more than NMASTERS-1 ownerships.
REQ-024 last_owner SHALL be ceil(log2(NMASTERS)) bits and wrap NMASTERS-1 -> 0.

Reset
REQ-025 p_reset high at a p_clk edge: state IDLE, grant_o 0, last_owner NMASTERS-1 (master 0 first), timeout counter 0.
REQ-026 Reset mid-transaction SHALL drop p_wb_CYC_O/STB_O from the next cycle; no termination is forwarded afterwards.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN defined: a counter increments each OWNED cycle with p_wb_STB_O high and no ACK/ERR/RTY, clears on any termination or STB low.
REQ-028 Counter reaching TIMEOUT_CYCLES: m_wb_ERR_O pulse one cycle to owner, slave CYC/STB forced 0, state ABORT.
REQ-029 ABORT: slave outputs 0, wait for owner CYC_I low, then IDLE with last_owner updated.
REQ-030 Macro undefined: no counter, no ABORT state; a stalled slave holds the bus indefinitely.

Structure
REQ-031 Package wb_arb_pkg SHALL hold the state enum, default NMASTERS, default TIMEOUT_CYCLES.
REQ-032 Sub-module wb_rr_picker (combinational: request vector + last_owner -> next owner index + valid).

Verification
REQ-033 Only master 0 CYC/STB write ADR 0x41000000 -> grant_o 01 next cycle, p_wb_ADR_O 0x41000000, ACK only on m_wb_ACK_O[0].
REQ-034 Both masters request from reset -> master 0 granted; after its CYC falls, one idle cycle, then master 1 granted.
REQ-035 Master 1 8-beat burst with CYC held, master 0 requesting throughout -> master 1 keeps all 8 beats, master 0 granted afterwards.
REQ-036 ACK and owner CYC fall in same cycle -> owner sees ACK, grant_o 0 next cycle.
REQ-037 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES 16, slave never acks -> owner ERR pulse on 16th stalled cycle, slave CYC 0, bus re-granted after owner drops CYC.
REQ-038 p_reset asserted during master 1 burst -> p_wb_CYC_O 0 next cycle, grant_o 0, master 0 first on next arbitration.
